// File: rtl/branch_redirect_if.sv
// -----------------------------------------------------------------------------
// branch_redirect_if
// Bundles the signals between the pipeline (hazard unit + EX branch unit) and
// the fetch-PC / redirect controller.
//   master : pipeline side, drives stall / ex_valid / pc_sel / br_pc and
//            observes pc, flush strobes, busy and misalign_err.
//   slave  : branch_redirect_ctrl side, the mirror image.
// When BRANCH_STATS_EN is defined the bundle also carries taken_cnt and
// flush_cyc_cnt (driven by the slave).
// -----------------------------------------------------------------------------
interface branch_redirect_if #(
  parameter int PC_W = 9
);
  logic            stall;
  logic            ex_valid;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic [PC_W-1:0] pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            redirect_busy;
  logic            misalign_err;
`ifdef BRANCH_STATS_EN
  logic [31:0]     taken_cnt;
  logic [31:0]     flush_cyc_cnt;

  modport master (
    output stall, ex_valid, pc_sel, br_pc,
    input  pc, flush_if_id, flush_id_ex, redirect_busy, misalign_err,
    input  taken_cnt, flush_cyc_cnt
  );
  modport slave (
    input  stall, ex_valid, pc_sel, br_pc,
    output pc, flush_if_id, flush_id_ex, redirect_busy, misalign_err,
    output taken_cnt, flush_cyc_cnt
  );
`else
  modport master (
    output stall, ex_valid, pc_sel, br_pc,
    input  pc, flush_if_id, flush_id_ex, redirect_busy, misalign_err
  );
  modport slave (
    input  stall, ex_valid, pc_sel, br_pc,
    output pc, flush_if_id, flush_id_ex, redirect_busy, misalign_err
  );
`endif
endinterface

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Owns the fetch PC. Advances it by 4 when fetch is not stalled, applies taken
// redirects from the EX branch unit, parks a redirect that arrives during a
// fetch stall until the stall clears, and raises the IF/ID and ID/EX flush
// strobes for FLUSH_CYCLES cycles starting with the cycle pc shows the target.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus (slave modport) :
//     in  stall, ex_valid, pc_sel, br_pc[31:0]
//     out pc[PC_W-1:0], flush_if_id, flush_id_ex, redirect_busy, misalign_err
//     out taken_cnt, flush_cyc_cnt   (only when BRANCH_STATS_EN is defined)
//
// Optional feature macro: BRANCH_STATS_EN (redirect / flush-cycle counters).
// All outputs are registered.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int              PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_redirect_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            misalign_q, misalign_d;
  logic            accept;

  // Target is word-aligned and silently truncated to the PC width.
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  assign target = {bus.br_pc[PC_W-1:2], 2'b00};
  assign pc_inc = pc_q + PC_W'(4);

  // Upper target bits are intentionally dropped.
  logic unused_br_hi;
  assign unused_br_hi = ^bus.br_pc[31:PC_W];

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_q, taken_d;
  logic [31:0] flush_cyc_q, flush_cyc_d;
`endif

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  // NOTE: every flop uses <= so all registers sample the pre-edge values, and
  // the async reset also discards any parked redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      misalign_q  <= 1'b0;
`ifdef BRANCH_STATS_EN
      taken_q     <= '0;
      flush_cyc_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      misalign_q  <= misalign_d;
`ifdef BRANCH_STATS_EN
      taken_q     <= taken_d;
      flush_cyc_q <= flush_cyc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and PC datapath
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.ex_valid && bus.pc_sel) begin
          accept = 1'b1;
          if (!bus.stall) begin
            pc_d    = target;
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end else begin
            pend_d  = target;
            state_d = HOLD;
          end
        end else if (!bus.stall) begin
          pc_d = pc_inc;
        end
      end
      // EX is frozen and keeps re-presenting the same branch, so ex_valid is
      // deliberately not looked at here.
      HOLD: begin
        if (!bus.stall) begin
          pc_d    = pend_q;
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      // Wrong-path instructions: redirects ignored. The flush length is fixed;
      // a stall only freezes the PC, it does not stretch the flush.
      FLUSH: begin
        if (!bus.stall) pc_d = pc_inc;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered-output next values (follow the state being entered)
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_d    = (state_d == FLUSH);
    busy_d     = (state_d != RUN);
    misalign_d = accept && (bus.br_pc[1:0] != 2'b00);
`ifdef BRANCH_STATS_EN
    taken_d     = taken_q + 32'(accept);
    flush_cyc_d = flush_cyc_q + 32'(flush_q);
`endif
  end

  assign bus.pc            = pc_q;
  assign bus.flush_if_id   = flush_q;
  assign bus.flush_id_ex   = flush_q;
  assign bus.redirect_busy = busy_q;
  assign bus.misalign_err  = misalign_q;
`ifdef BRANCH_STATS_EN
  assign bus.taken_cnt     = taken_q;
  assign bus.flush_cyc_cnt = flush_cyc_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Directed scenarios followed by random stimulus, compared every cycle against
// a behavioural model that tracks "fetch address", "parked target" and "flush
// cycles remaining" as plain integers.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  localparam int PC_W = 9;
  localparam int FC   = 2;
  localparam int MOD  = 1 << PC_W;

  logic clk;
  logic rst_n;

  branch_redirect_if #(.PC_W(PC_W)) bus ();

  branch_redirect_ctrl #(
    .PC_W(PC_W), .RESET_PC('0), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  int          m_pc;
  bit          m_parked;
  int          m_parked_tgt;
  int          m_flush_left;
  bit          m_misalign;
  longint      m_taken;
  longint      m_flush_cyc;

  task automatic model_reset();
    m_pc = 0; m_parked = 0; m_parked_tgt = 0; m_flush_left = 0;
    m_misalign = 0; m_taken = 0; m_flush_cyc = 0;
  endtask

  task automatic model_edge(input bit s, input bit ev, input bit ps, input logic [31:0] bp);
    bit acc;
    int tgt;
    acc = !m_parked && (m_flush_left == 0) && ev && ps;
    tgt = int'(bp % MOD) / 4 * 4;
    if (m_flush_left > 0) m_flush_cyc++;
    if (m_parked) begin
      if (!s) begin m_pc = m_parked_tgt; m_parked = 0; m_flush_left = FC; end
    end else if (m_flush_left > 0) begin
      if (!s) m_pc = (m_pc + 4) % MOD;
      m_flush_left--;
    end else if (acc) begin
      m_taken++;
      if (s) begin m_parked = 1; m_parked_tgt = tgt; end
      else begin m_pc = tgt; m_flush_left = FC; end
    end else if (!s) begin
      m_pc = (m_pc + 4) % MOD;
    end
    m_misalign = acc && (bp % 4 != 0);
  endtask

  task automatic compare_all();
    check("pc",            32'(bus.pc),         32'(m_pc));
    check("flush_if_id",   32'(bus.flush_if_id), 32'(m_flush_left > 0));
    check("flush_id_ex",   32'(bus.flush_id_ex), 32'(m_flush_left > 0));
    check("redirect_busy", 32'(bus.redirect_busy), 32'(m_parked || m_flush_left > 0));
    check("misalign_err",  32'(bus.misalign_err), 32'(m_misalign));
`ifdef BRANCH_STATS_EN
    check("taken_cnt",     bus.taken_cnt,     32'(m_taken));
    check("flush_cyc_cnt", bus.flush_cyc_cnt, 32'(m_flush_cyc));
`endif
  endtask

  // Called ~1 time unit after a rising edge: drive, clock, update model, compare.
  task automatic step(input bit s, input bit ev, input bit ps, input logic [31:0] bp);
    bus.stall = s; bus.ex_valid = ev; bus.pc_sel = ps; bus.br_pc = bp;
    @(posedge clk);
    model_edge(s, ev, ps, bp);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.pc_sel = 1'b0; bus.br_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",    32'(bus.pc), 32'h0);
    check("reset_busy",  32'(bus.redirect_busy), 32'h0);
    check("reset_flush", 32'(bus.flush_if_id), 32'h0);
    rst_n = 1'b1;

    // Walk to pc=0x010, then taken branch to 0x40.
    idle(4);
    check("pc_at_0x10", 32'(bus.pc), 32'h010);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    check("taken_target", 32'(bus.pc), 32'h040);
    idle(2);
    check("after_flush_pc", 32'(bus.pc), 32'h048);

    // Redirect under a 3-cycle stall, EX re-presents when stall clears.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h80);
    check("hold_no_flush", 32'(bus.flush_if_id), 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h80);
    check("hold_release_pc", 32'(bus.pc), 32'h080);
    idle(2);

    // Misaligned, wide target; then a redirect during FLUSH is ignored.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0206);
    check("misalign_pc", 32'(bus.pc), 32'h004);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check("misalign_one_shot", 32'(bus.misalign_err), 32'h0);
    idle(2);

    // Not-taken resolution in RUN, stall during flush.
    step(1'b0, 1'b1, 1'b0, 32'h1F0);
    step(1'b0, 1'b1, 1'b1, 32'h20);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    idle(1);

    // Walk to 0x1FC and wrap (bounded by model address space).
    for (int i = 0; i < MOD / 4 && m_pc != 32'h1FC; i++) idle(1);
    check("reach_0x1fc", 32'(bus.pc), 32'h1FC);
    idle(1);
    check("wrap_pc", 32'(bus.pc), 32'h000);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom);
    end

    // Async reset in the middle of a flush.
    idle(FC + 1);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    bus.ex_valid = 1'b0; bus.pc_sel = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc",    32'(bus.pc), 32'h0);
    check("async_rst_flush", 32'(bus.flush_if_id | bus.flush_id_ex), 32'h0);
    check("async_rst_busy",  32'(bus.redirect_busy), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_pc0", 32'(bus.pc), 32'h000);
    idle(1);
    check("post_rst_pc4", 32'(bus.pc), 32'h004);
    idle(1);
    check("post_rst_pc8", 32'(bus.pc), 32'h008);

`ifdef BRANCH_STATS_EN
    // Counters start from this reset: three redirects, FC flush cycles each.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'(32'h40 * (k + 1)));
      idle(FC + 1);
    end
    check("stats_taken", bus.taken_cnt, 32'd3);
    check("stats_flush", bus.flush_cyc_cnt, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
